count_checker: RTL and testbench

Sequence checker that consumes a stream of incrementing counter values over a valid/ready interface and verifies that each value is its predecessor plus one. It is the receiving end of the simulation stimulus counters: the counter drives values, and this block locks onto the first value, tracks expected values, counts errors and flags a configured hit value. After a configured number of beats it reports completion. It sits in the simulation top beside the stimulus counters; its outputs drive `$finish` and coverage.

---
 rtl/count_check_pkg.sv | 21 ++
 rtl/count_checker.sv | 175 +++++++++++++++++
 tb/tb_count_checker.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_check_pkg.sv
// -----------------------------------------------------------------------------
// count_check_pkg
// Shared types and constants for the count_checker sequence checker.
//   cc_state_t : checker state (IDLE waits for the first beat, TRACK compares
//                each beat against the expected value, DONE holds completion)
//   ERR_W      : width of the saturating mismatch counter
//   ERR_MAX    : saturation value of the mismatch counter
// -----------------------------------------------------------------------------
package count_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } cc_state_t;

  localparam int ERR_W = 16;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage : count_check_pkg

// File: rtl/count_checker.sv
// -----------------------------------------------------------------------------
// count_checker
// Receiving end of an incrementing-counter stimulus stream. The first accepted
// beat locks the checker. Every later beat must equal its predecessor plus one,
// modulo 2^WIDTH. Mismatches are counted with saturation, and a configured hit
// value is flagged. After DONE_COUNT accepted beats the checker stops accepting
// data and raises done.
//
// Parameters
//   WIDTH      : data width of the checked values
//   HIT_VALUE  : received value that pulses hit
//   DONE_COUNT : accepted beats before done (must be >= 1)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   clr        : synchronous clear back to IDLE; wins over a beat in the same cycle
//   in_valid   : in_data is presented
//   in_ready   : checker accepts data (depends on state only)
//   in_data    : received counter value
//   locked     : first beat has been received
//   mismatch   : one-cycle pulse, last accepted beat differed from expected
//   hit        : one-cycle pulse, last accepted beat equalled HIT_VALUE
//   err_count  : saturating mismatch count
//   rx_count   : accepted beats since reset or clear
//   done       : level, DONE_COUNT beats accepted
//
// Build option
//   COUNT_CHECK_RESYNC_EN : when defined, expected reloads from the received
//                           value after a mismatch, so one skipped value costs
//                           exactly one error. When undefined, expected always
//                           advances by one and a permanent offset errors on
//                           every beat.
// -----------------------------------------------------------------------------
module count_checker
  import count_check_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int HIT_VALUE  = 50,
  parameter  int DONE_COUNT = 100,
  localparam int RX_W       = $clog2(DONE_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             mismatch,
  output logic             hit,
  output logic [ERR_W-1:0] err_count,
  output logic [RX_W-1:0]  rx_count,
  output logic             done
);

  localparam logic [WIDTH-1:0] HIT_V     = WIDTH'(HIT_VALUE);
  localparam logic [RX_W-1:0]  LAST_IDX  = RX_W'(DONE_COUNT - 1);

  // State and registered outputs
  cc_state_t        r_state;
  logic [WIDTH-1:0] r_expected;
  logic [ERR_W-1:0] r_err_count;
  logic [RX_W-1:0]  r_rx_count;
  logic             r_in_ready;
  logic             r_locked;
  logic             r_mismatch;
  logic             r_hit;
  logic             r_done;

  // Combinational helpers
  logic             w_accept;
  logic             w_last;
  logic             w_is_hit;
  logic             w_differs;
  logic [WIDTH-1:0] w_data_inc;
  logic [WIDTH-1:0] w_expected_inc;
  logic [WIDTH-1:0] w_expected_next;
  logic [ERR_W-1:0] w_err_next;
  logic [RX_W-1:0]  w_rx_next;

  // r_in_ready is low only in DONE, so a beat is never accepted there.
  assign w_accept       = in_valid && r_in_ready;
  // This beat is the DONE_COUNT-th one. Because rx_count stops advancing in
  // DONE, it can never exceed DONE_COUNT.
  assign w_last         = (r_rx_count == LAST_IDX);
  assign w_is_hit       = (in_data == HIT_V);
  assign w_differs      = (in_data != r_expected);
  // Plain WIDTH-bit additions, so all-ones + 1 wraps to zero.
  assign w_data_inc     = in_data + WIDTH'(1);
  assign w_expected_inc = r_expected + WIDTH'(1);
  assign w_rx_next      = r_rx_count + RX_W'(1);
  assign w_err_next     = (r_err_count == ERR_MAX) ? r_err_count
                                                   : r_err_count + ERR_W'(1);

  // Expected value that follows a beat accepted in TRACK. On a matching beat
  // in_data + 1 equals expected + 1, so both builds agree there.
`ifdef COUNT_CHECK_RESYNC_EN
  assign w_expected_next = w_differs ? w_data_inc : w_expected_inc;
`else
  assign w_expected_next = w_expected_inc;
`endif

  // NOTE: all state lives in this one clocked block, and every register uses
  // non-blocking assignments. Blocking assignments here would let later
  // statements see the new values and create ordering races with other blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_expected  <= '0;
      r_err_count <= '0;
      r_rx_count  <= '0;
      r_in_ready  <= 1'b1;
      r_locked    <= 1'b0;
      r_mismatch  <= 1'b0;
      r_hit       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Pulses drop back to zero unless an accepted beat sets them again.
      r_mismatch <= 1'b0;
      r_hit      <= 1'b0;

      if (clr) begin
        // A beat presented in the same cycle as clr is dropped.
        r_state     <= IDLE;
        r_expected  <= '0;
        r_err_count <= '0;
        r_rx_count  <= '0;
        r_in_ready  <= 1'b1;
        r_locked    <= 1'b0;
        r_done      <= 1'b0;
      end else if (w_accept) begin
        r_hit      <= w_is_hit;
        r_rx_count <= w_rx_next;
        r_locked   <= 1'b1;

        unique case (r_state)
          IDLE: begin
            // The first beat only seeds the tracker. It is never a mismatch.
            r_expected <= w_data_inc;
          end
          TRACK: begin
            if (w_differs) begin
              r_mismatch  <= 1'b1;
              r_err_count <= w_err_next;
            end
            r_expected <= w_expected_next;
          end
          default: begin
            r_expected <= r_expected;
          end
        endcase

        // With DONE_COUNT = 1 the IDLE beat is also the last one and goes
        // straight to DONE.
        if (w_last) begin
          r_state    <= DONE;
          r_in_ready <= 1'b0;
          r_done     <= 1'b1;
        end else begin
          r_state    <= TRACK;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign locked    = r_locked;
  assign mismatch  = r_mismatch;
  assign hit       = r_hit;
  assign err_count = r_err_count;
  assign rx_count  = r_rx_count;
  assign done      = r_done;

endmodule : count_checker

// File: tb/tb_count_checker.sv
// -----------------------------------------------------------------------------
// tb_count_checker
// Directed bench for count_checker. The main instance is built with WIDTH=8,
// HIT_VALUE=50 and DONE_COUNT=100. A second instance with DONE_COUNT=1 covers
// the single-beat completion case. Each step drives one cycle of stimulus,
// pushes the expected outputs to a scoreboard queue, and compares them with the
// DUT one cycle later. The expected values for the configuration-dependent
// scenarios follow COUNT_CHECK_RESYNC_EN.
// -----------------------------------------------------------------------------
module tb_count_checker;

  localparam int W    = 8;
  localparam int HV   = 50;
  localparam int DC   = 100;
  localparam int RXW  = $clog2(DC + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           clr = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_ready;
  logic           locked;
  logic           mismatch;
  logic           hit;
  logic [15:0]    err_count;
  logic [RXW-1:0] rx_count;
  logic           done;

  // Single-beat instance
  logic           d1_valid = 1'b0;
  logic [31:0]    d1_data = '0;
  logic           d1_ready;
  logic           d1_locked;
  logic           d1_mismatch;
  logic           d1_hit;
  logic [15:0]    d1_err;
  logic [0:0]     d1_rx;
  logic           d1_done;

  always #5 clk = ~clk;

  count_checker #(.WIDTH(W), .HIT_VALUE(HV), .DONE_COUNT(DC)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .locked    (locked),
    .mismatch  (mismatch),
    .hit       (hit),
    .err_count (err_count),
    .rx_count  (rx_count),
    .done      (done)
  );

  count_checker #(.WIDTH(32), .HIT_VALUE(50), .DONE_COUNT(1)) u_dc1 (
    .clk       (clk),
    .reset     (reset),
    .clr       (1'b0),
    .in_valid  (d1_valid),
    .in_ready  (d1_ready),
    .in_data   (d1_data),
    .locked    (d1_locked),
    .mismatch  (d1_mismatch),
    .hit       (d1_hit),
    .err_count (d1_err),
    .rx_count  (d1_rx),
    .done      (d1_done)
  );

  typedef struct {
    logic           mm;
    logic           hit;
    logic           locked;
    logic           done;
    logic           ready;
    logic [15:0]    err;
    logic [RXW-1:0] rx;
  } exp_t;

  exp_t         sb[$];

  // Behavioural reference state: 0 = idle, 1 = tracking, 2 = done
  int           m_state;
  logic [W-1:0] m_exp;
  logic [15:0]  m_err;
  int           m_rx;

  int n_assert  = 0;
  int n_fail    = 0;
  int hit_total = 0;
  int mm_total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_exp   = '0;
    m_err   = '0;
    m_rx    = 0;
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("mismatch",  32'(mismatch),  32'(e.mm));
      check("hit",       32'(hit),       32'(e.hit));
      check("locked",    32'(locked),    32'(e.locked));
      check("done",      32'(done),      32'(e.done));
      check("in_ready",  32'(in_ready),  32'(e.ready));
      check("err_count", 32'(err_count), 32'(e.err));
      check("rx_count",  32'(rx_count),  32'(e.rx));
      hit_total += int'(hit);
      mm_total  += int'(mismatch);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic c);
    exp_t e;
    in_valid = v;
    in_data  = d;
    clr      = c;
    e.mm  = 1'b0;
    e.hit = 1'b0;
    if (c) begin
      model_reset();
    end else if (v && m_state != 2) begin
      e.hit = (d == W'(HV));
      if (m_state == 0) begin
        m_exp = d + W'(1);
      end else if (d != m_exp) begin
        e.mm = 1'b1;
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
`ifdef COUNT_CHECK_RESYNC_EN
        m_exp = d + W'(1);
`else
        m_exp = m_exp + W'(1);
`endif
      end else begin
        m_exp = m_exp + W'(1);
      end
      m_rx++;
      m_state = (m_rx == DC) ? 2 : 1;
    end
    e.locked = (m_state != 0);
    e.done   = (m_state == 2);
    e.ready  = (m_state != 2);
    e.err    = m_err;
    e.rx     = RXW'(m_rx);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    logic [W-1:0] d;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready),  32'd1);
    check("rst_locked",   32'(locked),    32'd0);
    check("rst_mismatch", 32'(mismatch),  32'd0);
    check("rst_hit",      32'(hit),       32'd0);
    check("rst_err",      32'(err_count), 32'd0);
    check("rst_rx",       32'(rx_count),  32'd0);
    check("rst_done",     32'(done),      32'd0);
    check("rst_d1_ready", 32'(d1_ready),  32'd1);
    reset = 1'b1;
    step(1'b0, '0, 1'b0);

    // 0..99 back to back: no errors, one hit, done after beat 100
    hit_total = 0;
    for (int i = 0; i < DC; i++) step(1'b1, W'(i), 1'b0);
    check("run_err",      32'(err_count), 32'd0);
    check("run_hits",     32'(hit_total), 32'd1);
    check("run_done",     32'(done),      32'd1);
    check("run_ready",    32'(in_ready),  32'd0);
    // A beat offered in DONE is ignored.
    step(1'b1, 8'd123, 1'b0);
    check("done_rx_hold", 32'(rx_count),  32'd100);

    // Skipped value: 10,11,13,14,15
    step(1'b0, '0, 1'b1);
    mm_total = 0;
    step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd11, 1'b0);
    step(1'b1, 8'd13, 1'b0);
    step(1'b1, 8'd14, 1'b0);
    step(1'b1, 8'd15, 1'b0);
`ifdef COUNT_CHECK_RESYNC_EN
    check("skip_err",     32'(err_count), 32'd1);
    check("skip_pulses",  32'(mm_total),  32'd1);
`else
    check("skip_err",     32'(err_count), 32'd3);
    check("skip_pulses",  32'(mm_total),  32'd3);
`endif

    // Wrap: FE, FF, 00, 01
    step(1'b0, '0, 1'b1);
    step(1'b1, 8'hFE, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    check("wrap_err",     32'(err_count), 32'd0);

    // clr beats a same-cycle beat in TRACK with rx_count = 5
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, W'(i), 1'b0);
    check("pre_clr_rx",   32'(rx_count),  32'd5);
    step(1'b1, 8'd77, 1'b1);
    check("clr_rx",       32'(rx_count),  32'd0);
    check("clr_locked",   32'(locked),    32'd0);
    step(1'b1, 8'd200, 1'b0);
    check("relock_mm",    32'(mismatch),  32'd0);
    check("relock_rx",    32'(rx_count),  32'd1);

    // Gap of three idle cycles inside an in-order stream
    mm_total = 0;
    step(1'b1, 8'd201, 1'b0);
    step(1'b1, 8'd202, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'hAA, 1'b0);
    check("gap_rx",       32'(rx_count),  32'd3);
    step(1'b1, 8'd203, 1'b0);
    step(1'b1, 8'd204, 1'b0);
    check("gap_mm",       32'(mm_total),  32'd0);

    // Reach rx_count = 40 with err_count = 2, then reset mid-operation
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 40; i++) begin
`ifdef COUNT_CHECK_RESYNC_EN
      d = W'(i + int'(i >= 15) + int'(i >= 30));
`else
      d = (i == 15 || i == 30) ? 8'hAA : W'(i);
`endif
      step(1'b1, d, 1'b0);
    end
    check("pre_rst_rx",   32'(rx_count),  32'd40);
    check("pre_rst_err",  32'(err_count), 32'd2);
    in_valid = 1'b0;
    reset    = 1'b0;
    #2;
    check("arst_in_ready", 32'(in_ready),  32'd1);
    check("arst_locked",   32'(locked),    32'd0);
    check("arst_mismatch", 32'(mismatch),  32'd0);
    check("arst_hit",      32'(hit),       32'd0);
    check("arst_err",      32'(err_count), 32'd0);
    check("arst_rx",       32'(rx_count),  32'd0);
    check("arst_done",     32'(done),      32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 8'd50, 1'b0);
    check("post_rst_hit", 32'(hit),       32'd1);

    // DONE_COUNT = 1: the first beat completes the run.
    d1_valid = 1'b1;
    d1_data  = 32'd50;
    @(posedge clk);
    #1;
    d1_valid = 1'b0;
    check("dc1_done",     32'(d1_done),     32'd1);
    check("dc1_ready",    32'(d1_ready),    32'd0);
    check("dc1_hit",      32'(d1_hit),      32'd1);
    check("dc1_locked",   32'(d1_locked),   32'd1);
    check("dc1_mismatch", 32'(d1_mismatch), 32'd0);
    check("dc1_rx",       32'(d1_rx),       32'd1);
    d1_valid = 1'b1;
    d1_data  = 32'd7;
    @(posedge clk);
    #1;
    d1_valid = 1'b0;
    check("dc1_hold_done", 32'(d1_done),   32'd1);
    check("dc1_hold_hit",  32'(d1_hit),    32'd0);
    check("dc1_hold_err",  32'(d1_err),    32'd0);
    check("dc1_hold_rx",   32'(d1_rx),     32'd1);

    check("sb_drained",   32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_count_checker
